imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that writes the 16-bit instruction memory from a byte stream, acting as the writer for the core's instruction-fetch reader. It holds the core in reset while loading, assembles little-endian byte pairs into instruction words, and writes them to consecutive addresses starting at 0. It releases the core only after a complete, valid image has been written. It sits between a host byte source (UART receiver or testbench) and the instruction memory write port (`we`, address, data).

## Interface
- ADDR_W, 12: instruction memory address width; capacity is 2**ADDR_W words, so 4096 words covers PC range 0x0000..0x0fff.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction memory write enable; one-cycle pulse per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  write data.
- core_rst  out  1  reset hold for the core; high whenever no valid image is loaded.
- busy  out  1  high while a load is in progress.
- done  out  1  high in DONE.
- err  out  1  high in ERR.
- words_written  out  ADDR_W+1  count of words written in the current load.

## Operation
- A byte transfers on a rising edge when in_valid=1 and in_ready=1. in_data is ignored otherwise.
- Stream format:
  - LEN_LO, then LEN_HI: a 16-bit word count N.
  - N words follow, each sent as low byte then high byte.
  - With the checksum feature compiled in, one checksum byte follows the last word.
- States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECK (only with the checksum feature), DONE, ERR.
- IDLE: in_ready=0 and core_rst=1. start moves to LEN_LO, clears words_written, and sets the address pointer to 0.
- LEN_LO and LEN_HI: in_ready=1. Each state captures its length byte.
- After LEN_HI:
  - N > 2**ADDR_W goes to ERR.
  - N = 0 goes to CHECK if the checksum feature is compiled in, otherwise to DONE.
  - Any other N goes to DATA_LO.
- DATA_LO: latches the low byte. DATA_HI: latches the high byte and goes to WRITE.
- WRITE: in_ready=0 and mem_we=1 for exactly one cycle. mem_addr is the pointer; mem_wdata is {hi, lo}. The pointer and words_written increment. The state then goes to DATA_LO if words_written+1 < N, otherwise to CHECK or DONE.
- DONE: core_rst=0, done=1, in_ready=0. The core runs. start re-enters LEN_LO and raises core_rst on the next edge.
- ERR: err=1, core_rst=1, in_ready=0. Only start or rst exits ERR.
- busy=1 in LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE and CHECK. start is ignored while busy.
- mem_addr and mem_wdata hold their last value when mem_we=0.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, busy=0, done=0, err=0, words_written=0. State returns to IDLE.
- All outputs are registered or decoded from state. No output depends combinationally on in_valid or in_data.
- Throughput: at least 3 cycles per word (2 byte cycles plus 1 WRITE cycle). With continuous in_valid, a load of N words finishes in 2 + 3N cycles after the first byte is accepted, plus 1 cycle with the checksum feature.
- start to in_ready=1: 1 cycle.
- Last WRITE (or CHECK) to core_rst=0: the next edge.
- rst during a load aborts it immediately. No further mem_we pulses occur. Memory contents already written are left as they are. core_rst stays 1.
- Word count is at most 2**ADDR_W, so the address pointer never wraps within one load. N = 4096 writes addresses 0..0xfff.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - The CHECK state exists and accepts one byte.
  - The checksum byte must equal the mod-256 sum of every earlier byte in the stream, including both length bytes.
  - Match goes to DONE; mismatch goes to ERR, and core_rst stays 1.
  - The running sum clears on start.
- IMEM_LOADER_CHECKSUM_EN undefined:
  - There is no CHECK state and no sum register.
  - The final WRITE goes directly to DONE, and N = 0 goes from LEN_HI to DONE.

## Test plan
- After rst, with no start for 20 cycles: core_rst=1, in_ready=0, mem_we never asserts.
- start, then bytes 02 00 13 00 37 A1 with in_valid held high (macro off):
  - mem_we at addr 0 with 0x0013, then at addr 1 with 0xA137.
  - done=1, core_rst=0, words_written=2.
- Length bytes 01 10 (N=4097): err=1 after LEN_HI, no mem_we, core_rst=1. A later start followed by a valid 1-word image ends in DONE.
- in_valid toggled 1-0-1 on alternate cycles during a 3-word load: exactly 3 writes, correct data, no byte lost or duplicated.
- rst asserted in the cycle after the second payload byte of a 4-word load: next cycle in IDLE, with all outputs at reset values and no further writes.
- With macro on, stream 01 00 34 12 followed by checksum 47 (0x01+0x00+0x34+0x12): DONE. The same stream with checksum 48: ERR, core_rst=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// Host byte stream, instruction-memory write port and loader status, bundled for imem_loader.
// slave = the loader itself, master = the host/memory side driving start and the byte stream.
interface imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_written;

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, core_rst, busy, done, err, words_written
  );

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, core_rst, busy, done, err, words_written
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian word image into instruction memory, holding the core in reset until done.
// Optional trailing mod-256 checksum byte when IMEM_LOADER_CHECKSUM_EN is defined; 3 cycles/word, in_ready decoded from state.
module imem_loader #(
  parameter int ADDR_W = 12
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_q;
  logic [7:0]        lo_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  logic              rdy, we, core_rst, busy, done, err;
  logic              xfer, start_ok, more_words;
  logic [15:0]       n_full;
  logic [ADDR_W:0]   words_next;

  assign xfer       = bus.in_valid && rdy;
  assign start_ok   = bus.start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign n_full     = {bus.in_data, len_lo_q};
  // words_q doubles as the write pointer, so addresses stay contiguous from 0
  assign words_next = words_q + {{ADDR_W{1'b0}}, 1'b1};
  assign more_words = 16'(words_next) < len_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (bus.start) state_d = S_LEN_LO;
      S_LEN_LO:  if (xfer) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if ({1'b0, n_full} > MAX_WORDS) state_d = S_ERR;
`ifdef IMEM_LOADER_CHECKSUM_EN
          else if (n_full == 16'd0)       state_d = S_CHECK;
`else
          else if (n_full == 16'd0)       state_d = S_DONE;
`endif
          else                            state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: if (xfer) state_d = S_DATA_HI;
      S_DATA_HI: if (xfer) state_d = S_WRITE;
      S_WRITE: begin
        if (more_words) state_d = S_DATA_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else            state_d = S_CHECK;
`else
        else            state_d = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: if (xfer) state_d = (bus.in_data == sum_q) ? S_DONE : S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdy      = 1'b0;
    we       = 1'b0;
    core_rst = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI: begin
        rdy  = 1'b1;
        busy = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        rdy  = 1'b1;
        busy = 1'b1;
      end
`endif
      S_WRITE: begin
        we   = 1'b1;
        busy = 1'b1;
      end
      S_DONE: begin
        core_rst = 1'b0;
        done     = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo_q <= '0;
      len_q    <= '0;
      lo_q     <= '0;
      words_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      if (start_ok) words_q <= '0;
      case (state_q)
        S_LEN_LO:  if (xfer) len_lo_q <= bus.in_data;
        S_LEN_HI:  if (xfer) len_q <= n_full;
        S_DATA_LO: if (xfer) lo_q <= bus.in_data;
        // Write-port registers load only here, so they hold between pulses
        S_DATA_HI: if (xfer) begin
          addr_q  <= words_q[ADDR_W-1:0];
          wdata_q <= {bus.in_data, lo_q};
        end
        S_WRITE:   words_q <= words_next;
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)                              sum_q <= '0;
    else if (start_ok)                    sum_q <= '0;
    else if (xfer && state_q != S_CHECK)  sum_q <= sum_q + bus.in_data;
  end
`endif

  assign bus.in_ready      = rdy;
  assign bus.mem_we        = we;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.core_rst      = core_rst;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.err           = err;
  assign bus.words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as the image is built and popped on each mem_we.
module tb_imem_loader;
  localparam int AW = 12;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int LAT       = 0;
  localparam int CYC_EXTRA = 3;
`else
  localparam int LAT       = 1;
  localparam int CYC_EXTRA = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(AW)) bus ();
  imem_loader #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_tot = 0;
  int n_bad = 0;
  int n_we  = 0;
  int cyc;
  int w0;
  logic [7:0]     tx_q[$];
  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      n_we++;
      chk("we_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("we_addr", 32'(bus.mem_addr), 32'(mon_e[AW+15:16]));
        chk("we_data", 32'(bus.mem_wdata), 32'(mon_e[15:0]));
      end
    end
  end

  task automatic begin_image(input logic [15:0] n);
    tx_q.delete();
    tx_q.push_back(n[7:0]);
    tx_q.push_back(n[15:8]);
  endtask

  task automatic add_word(input logic [AW-1:0] a, input logic [15:0] d);
    tx_q.push_back(d[7:0]);
    tx_q.push_back(d[15:8]);
    exp_q.push_back({a, d});
  endtask

  task automatic end_image();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] s;
    s = 8'd0;
    foreach (tx_q[i]) s = s + tx_q[i];
    tx_q.push_back(s);
`endif
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_in_ready", 32'(bus.in_ready), 32'd1);
    chk("start_core_rst", 32'(bus.core_rst), 32'd1);
    chk("start_busy", 32'(bus.busy), 32'd1);
  endtask

  // Drives tx_q from a negedge; returns on the negedge after the last accepted byte.
  task automatic send_bytes(input bit toggle, output int ncyc);
    int  i = 0;
    bit  v = 1'b1;
    bit  acc;
    ncyc = 0;
    while (i < tx_q.size() && ncyc < 20000) begin
      bus.in_valid = toggle ? v : 1'b1;
      bus.in_data  = bus.in_valid ? tx_q[i] : 8'($urandom);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (acc) i++;
      v = ~v;
      ncyc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    chk("bytes_sent", 32'(i), 32'(tx_q.size()));
  endtask

  task automatic wait_end(input int exp_lat);
    int c = 0;
    while (!(bus.done || bus.err) && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("end_latency", 32'(c), 32'(exp_lat));
    #1;
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals();
    chk("rv_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rv_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rv_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rv_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rv_core_rst", 32'(bus.core_rst), 32'd1);
    chk("rv_busy", 32'(bus.busy), 32'd0);
    chk("rv_done", 32'(bus.done), 32'd0);
    chk("rv_err", 32'(bus.err), 32'd0);
    chk("rv_words", 32'(bus.words_written), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within 2000000 time units");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset, no start
    repeat (20) @(negedge clk);
    check_reset_vals();
    chk("idle_we_count", 32'(n_we), 32'd0);

    // Two-word image, continuous valid
    do_start();
    begin_image(16'd2);
    add_word(12'd0, 16'h0013);
    add_word(12'd1, 16'hA137);
    end_image();
    send_bytes(1'b0, cyc);
    chk("two_word_cycles", 32'(cyc), 32'(3 * 2 + CYC_EXTRA));
    wait_end(LAT);
    chk("two_done", 32'(bus.done), 32'd1);
    chk("two_core_rst", 32'(bus.core_rst), 32'd0);
    chk("two_words", 32'(bus.words_written), 32'd2);
    chk("two_err", 32'(bus.err), 32'd0);
    chk("two_in_ready", 32'(bus.in_ready), 32'd0);

    // Oversized length goes to ERR with no writes, then recovers
    w0 = n_we;
    do_start();
    begin_image(16'd4097);
    send_bytes(1'b0, cyc);
    wait_end(0);
    chk("big_err", 32'(bus.err), 32'd1);
    chk("big_core_rst", 32'(bus.core_rst), 32'd1);
    chk("big_done", 32'(bus.done), 32'd0);
    chk("big_busy", 32'(bus.busy), 32'd0);
    chk("big_no_writes", 32'(n_we - w0), 32'd0);
    do_start();
    begin_image(16'd1);
    add_word(12'd0, 16'hBEEF);
    end_image();
    send_bytes(1'b0, cyc);
    wait_end(LAT);
    chk("recover_done", 32'(bus.done), 32'd1);
    chk("recover_err", 32'(bus.err), 32'd0);
    chk("recover_words", 32'(bus.words_written), 32'd1);

    // Gappy valid, three words
    w0 = n_we;
    do_start();
    begin_image(16'd3);
    add_word(12'd0, 16'h2211);
    add_word(12'd1, 16'h4433);
    add_word(12'd2, 16'h6655);
    end_image();
    send_bytes(1'b1, cyc);
    wait_end(LAT);
    chk("tog_writes", 32'(n_we - w0), 32'd3);
    chk("tog_words", 32'(bus.words_written), 32'd3);
    chk("tog_done", 32'(bus.done), 32'd1);

    // Empty image
    w0 = n_we;
    do_start();
    begin_image(16'd0);
    end_image();
    send_bytes(1'b0, cyc);
    wait_end(0);
    chk("empty_done", 32'(bus.done), 32'd1);
    chk("empty_words", 32'(bus.words_written), 32'd0);
    chk("empty_no_writes", 32'(n_we - w0), 32'd0);

    // Full-capacity image
    do_start();
    begin_image(16'd4096);
    for (int i = 0; i < 4096; i++)
      add_word(AW'(i), 16'(i * 37 + 5) ^ 16'h1234);
    end_image();
    send_bytes(1'b0, cyc);
    chk("full_cycles", 32'(cyc), 32'(3 * 4096 + CYC_EXTRA));
    wait_end(LAT);
    chk("full_done", 32'(bus.done), 32'd1);
    chk("full_words", 32'(bus.words_written), 32'd4096);
    chk("full_last_addr", 32'(bus.mem_addr), 32'hfff);

    // Reset during the first WRITE of a 4-word load
    do_start();
    begin_image(16'd4);
    add_word(12'd0, 16'hBBAA);
    send_bytes(1'b0, cyc);
    chk("abort_in_write", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals();
    w0 = n_we;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("abort_no_writes", 32'(n_we - w0), 32'd0);
    chk("abort_pending", 32'(exp_q.size()), 32'd0);
    chk("abort_core_rst", 32'(bus.core_rst), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum accept and reject
    do_start();
    begin_image(16'd1);
    add_word(12'd0, 16'h1234);
    tx_q.push_back(8'h47);
    send_bytes(1'b0, cyc);
    wait_end(0);
    chk("cks_good_done", 32'(bus.done), 32'd1);
    chk("cks_good_core_rst", 32'(bus.core_rst), 32'd0);
    do_start();
    begin_image(16'd1);
    add_word(12'd0, 16'h1234);
    tx_q.push_back(8'h48);
    send_bytes(1'b0, cyc);
    wait_end(0);
    chk("cks_bad_err", 32'(bus.err), 32'd1);
    chk("cks_bad_done", 32'(bus.done), 32'd0);
    chk("cks_bad_core_rst", 32'(bus.core_rst), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
